canxl_crc_engine: RTL and testbench

CANXL_CRC_ENGINE -- requirements
Module: canxl_crc_engine

---
 rtl/canxl_crc_engine.sv | 120 ++++++++++++
 tb/tb_canxl_crc_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/canxl_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : canxl_crc_engine
// Brief    : Bit-serial / beat-parallel CAN XL CRC engine with frame control
//            FSM (IDLE/RUN/DONE) and optional residue checker, compiled in by
//            defining CANXL_CRC_RESIDUE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module canxl_crc_engine #(
    parameter int                 CRC_W = 13,
    parameter logic [CRC_W-1:0]   POLY  = 13'h19E7,
    parameter logic [CRC_W-1:0]   INIT  = '0,
    parameter int                 DIN_W = 1
) (
    input  logic             clk,
    input  logic             g_rst,
    input  logic             start,
    input  logic             abort,
    input  logic             din_vld,
    input  logic [DIN_W-1:0] din,
    input  logic             finish,
    output logic [CRC_W-1:0] crc,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic [15:0]      bit_cnt
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_run  = 2'd1;
    localparam logic [1:0]  c_st_done = 2'd2;
    localparam logic [16:0] c_cnt_max = 17'h0FFFF;
    localparam logic [16:0] c_cnt_inc = 17'(DIN_W);

    logic [1:0]       r_state;
    logic [CRC_W-1:0] r_crc;
    logic [15:0]      r_bit_cnt;
    logic             r_done;
    logic [CRC_W-1:0] w_crc_next;
    logic [CRC_W-1:0] w_crc_fin;
    logic [16:0]      w_cnt_sum;
    logic [15:0]      w_cnt_next;

    // MSB of the beat enters the register first; all DIN_W steps chain in one cycle.
    function automatic logic [CRC_W-1:0] f_absorb(input logic [CRC_W-1:0] crc_in,
                                                  input logic [DIN_W-1:0] data);
        logic [CRC_W-1:0] acc;
        logic             fb;
        acc = crc_in;
        for (int i = DIN_W - 1; i >= 0; i--) begin
            fb  = data[i] ^ acc[CRC_W-1];
            acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return acc;
    endfunction

    always_comb begin
        w_crc_next = f_absorb(r_crc, din);
        w_crc_fin  = din_vld ? w_crc_next : r_crc;
        w_cnt_sum  = {1'b0, r_bit_cnt} + c_cnt_inc;
        w_cnt_next = (w_cnt_sum > c_cnt_max) ? 16'hFFFF : w_cnt_sum[15:0];
    end

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            r_state   <= c_st_idle;
            r_crc     <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state   <= c_st_idle;
                r_crc     <= '0;
                r_bit_cnt <= '0;
            end else if (start) begin
                r_state   <= c_st_run;
                r_crc     <= INIT;
                r_bit_cnt <= '0;
            end else if (r_state == c_st_run) begin
                if (din_vld) begin
                    r_crc     <= w_crc_next;
                    r_bit_cnt <= w_cnt_next;
                end
                if (finish) begin
                    r_state <= c_st_done;
                    r_done  <= 1'b1;
                end
            end
        end
    end

`ifdef CANXL_CRC_RESIDUE_CHECK_EN
    logic r_crc_ok;

    // Residue is judged on the CRC including a beat absorbed alongside finish.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            r_crc_ok <= 1'b0;
        end else if (abort || start) begin
            r_crc_ok <= 1'b0;
        end else if (r_state == c_st_run && finish) begin
            r_crc_ok <= (w_crc_fin == '0);
        end
    end

    assign crc_ok = r_crc_ok;
`else
    logic w_unused;
    assign w_unused = |w_crc_fin;
    assign crc_ok   = 1'b0;
`endif

    assign crc     = r_crc;
    assign bit_cnt = r_bit_cnt;
    assign busy    = (r_state == c_st_run);
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_canxl_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_canxl_crc_engine
// Brief    : Self-checking bench; polynomial-division model plus literal pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_canxl_crc_engine;

    logic        clk;
    logic        g_rst;
    logic        start;
    logic        abort;
    logic        din_vld;
    logic [0:0]  din;
    logic        finish;
    logic [12:0] crc;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic [15:0] bit_cnt;

    logic        din_vld4;
    logic [3:0]  din4;
    logic [12:0] crc4;
    logic        busy4;
    logic        done4;
    logic        crc_ok4;
    logic [15:0] bit_cnt4;

    int checks = 0;
    int errors = 0;

    canxl_crc_engine dut (
        .clk(clk), .g_rst(g_rst), .start(start), .abort(abort),
        .din_vld(din_vld), .din(din), .finish(finish),
        .crc(crc), .busy(busy), .done(done), .crc_ok(crc_ok), .bit_cnt(bit_cnt)
    );

    canxl_crc_engine #(.DIN_W(4)) dut4 (
        .clk(clk), .g_rst(g_rst), .start(start), .abort(abort),
        .din_vld(din_vld4), .din(din4), .finish(finish),
        .crc(crc4), .busy(busy4), .done(done4), .crc_ok(crc_ok4), .bit_cnt(bit_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of M(x)*x^13 divided by the full generator x^13 + POLY.
    function automatic logic [12:0] rem_of(input bit q[$]);
        logic [13:0] r;
        int n;
        r = '0;
        n = q.size();
        for (int i = 0; i < n + 13; i++) begin
            r = {r[12:0], (i < n) ? q[i] : 1'b0};
            if (r[13]) r = r ^ 14'h39E7;
        end
        return r[12:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Frame model: 0=idle 1=run 2=done
    int  m_state = 0;
    bit  m_bits[$];
    int  m_cnt = 0;
    bit  m_done = 0;
    bit  m_ok = 0;

    function automatic bit exp_ok(input bit q[$]);
`ifdef CANXL_CRC_RESIDUE_CHECK_EN
        return rem_of(q) == 13'h0;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            m_state = 0; m_bits.delete(); m_cnt = 0; m_done = 0; m_ok = 0;
        end else begin
            m_done = 0;
            if (abort) begin
                m_state = 0; m_bits.delete(); m_cnt = 0; m_ok = 0;
            end else if (start) begin
                m_state = 1; m_bits.delete(); m_cnt = 0; m_ok = 0;
            end else if (m_state == 1) begin
                if (din_vld) begin
                    m_bits.push_back(din[0]);
                    m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
                end
                if (finish) begin
                    m_state = 2; m_done = 1; m_ok = exp_ok(m_bits);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!g_rst) begin
            chk("crc", 32'(crc), 32'(rem_of(m_bits)));
            chk("busy", 32'(busy), 32'(m_state == 1));
            chk("done", 32'(done), 32'(m_done));
            chk("crc_ok", 32'(crc_ok), 32'(m_ok));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
        end
    end

    task automatic tick(input logic s, input logic a, input logic v, input logic d, input logic f);
        @(negedge clk);
        start = s; abort = a; din_vld = v; din = d; finish = f;
        din_vld4 = v; din4 = {d, 3'b000};
        @(posedge clk);
        #2;
    endtask

    logic [12:0] c_word;

    initial begin
        g_rst = 1'b1; start = 0; abort = 0; din_vld = 0; din = 0; finish = 0;
        din_vld4 = 0; din4 = 0;
        c_word = 13'h19E7;
        #3;
        chk("rst_crc", 32'(crc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_cnt", 32'(bit_cnt), 32'h0);
        chk("rst_ok", 32'(crc_ok), 32'h0);
        @(negedge clk);
        g_rst = 1'b0;

        tick(0, 0, 0, 0, 0);
        chk("post_rst_busy", 32'(busy), 32'h0);
        tick(0, 0, 1, 1, 1);
        chk("idle_vld_crc", 32'(crc), 32'h0);
        chk("idle_fin_done", 32'(done), 32'h0);

        // single beat with finish
        tick(1, 0, 0, 0, 0);
        chk("start_busy", 32'(busy), 32'h1);
        tick(0, 0, 1, 1, 1);
        chk("one_bit_crc", 32'(crc), 32'h19E7);
        chk("one_bit_cnt", 32'(bit_cnt), 32'h1);
        chk("one_bit_done", 32'(done), 32'h1);
        tick(0, 0, 1, 0, 0);
        chk("done_pulse_end", 32'(done), 32'h0);
        chk("done_frozen_crc", 32'(crc), 32'h19E7);

        // two beats; DIN_W=4 instance sees 4'b1000 on the first
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        chk("w4_crc", 32'(crc4), 32'h1143);
        chk("w4_cnt", 32'(bit_cnt4), 32'h4);
        tick(0, 0, 1, 0, 0);
        chk("two_bit_crc", 32'(crc), 32'h0A29);
        tick(1, 0, 0, 0, 0);
        chk("restart_crc", 32'(crc), 32'h0);
        chk("restart_cnt", 32'(bit_cnt), 32'h0);

        // message followed by its own CRC leaves zero residue
        tick(0, 0, 1, 1, 0);
        for (int i = 12; i >= 0; i--) tick(0, 0, 1, c_word[i], i == 0);
        chk("residue_crc", 32'(crc), 32'h0);
        chk("residue_cnt", 32'(bit_cnt), 32'd14);
        chk("residue_done", 32'(done), 32'h1);
        chk("residue_ok", 32'(crc_ok), 32'(exp_ok('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1})));

        // finish without a beat
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 1);
        chk("fin_only_crc", 32'(crc), 32'h19E7);

        // abort wins over start/din_vld
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(1, 1, 1, 1, 1);
        chk("abort_crc", 32'(crc), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_cnt", 32'(bit_cnt), 32'h0);

        // asynchronous reset mid-RUN
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        #2;
        g_rst = 1'b1;
        #1;
        chk("async_rst_crc", 32'(crc), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        g_rst = 1'b0;
        tick(0, 0, 0, 0, 0);

        // bit_cnt saturation on the 4-bit instance
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 16383; i++) begin
            @(negedge clk);
            start = 0; din_vld = 0; din_vld4 = 1; din4 = 4'hA;
        end
        @(negedge clk);
        din_vld4 = 0;
        #1;
        chk("sat_pre_cnt", 32'(bit_cnt4), 32'd65532);
        @(negedge clk);
        din_vld4 = 1;
        @(posedge clk);
        #2;
        chk("sat_cnt", 32'(bit_cnt4), 32'hFFFF);
        @(posedge clk);
        #2;
        chk("sat_hold_cnt", 32'(bit_cnt4), 32'hFFFF);
        @(negedge clk);
        din_vld4 = 0;
        tick(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
